// File: rtl/serial_frame_transmitter_if.sv
// Bundle of the start/data request and tx/busy/done status signals
// exchanged between a frame source (master) and the transmitter (slave).
interface serial_frame_transmitter_if #(
    parameter int WIDTH = 8
);
    logic             input_push_button3_start_3;
    logic [WIDTH-1:0] input_switch4_data_4;
    logic             output_led1_tx_5;
    logic             output_led2_busy_6;
    logic             output_led3_done_7;

    modport master (
        output input_push_button3_start_3,
        output input_switch4_data_4,
        input  output_led1_tx_5,
        input  output_led2_busy_6,
        input  output_led3_done_7
    );

    modport slave (
        input  input_push_button3_start_3,
        input  input_switch4_data_4,
        output output_led1_tx_5,
        output output_led2_busy_6,
        output output_led3_done_7
    );
endinterface

// File: rtl/serial_frame_transmitter.sv
// Parallel-in, serial-out frame transmitter. Sends start bit (0), WIDTH data
// bits MSB first, an optional even-parity bit and a stop bit (1), each bit
// held for BIT_CYCLES clocks. tx, busy and done are all registered; their
// next values are derived from the next state so a bit appears on tx on the
// same edge its state is entered.
module serial_frame_transmitter #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 0
) (
    input  logic                       input_clock1_clk_1,
    input  logic                       input_push_button2_rst_n_2,
    serial_frame_transmitter_if.slave  bus
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_r,  state_s;
    logic [WIDTH-1:0] shift_r,  shift_s;
    logic             parity_r, parity_s;
    logic [CW-1:0]    cyc_r,    cyc_s;
    logic [BW-1:0]    bit_r,    bit_s;
    logic             tx_r,     tx_s;
    logic             busy_r,   busy_s;
    logic             done_r,   done_s;
    logic             bit_end_s;
    logic             start_s;
    logic [WIDTH-1:0] data_s;

    // Even parity over the data word: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    assign start_s   = bus.input_push_button3_start_3;
    assign data_s    = bus.input_switch4_data_4;
    assign bit_end_s = (cyc_r == CYC_LAST);

    // Next-state, counter and shift-register logic plus next registered outputs.
    always_comb begin
        state_s  = state_r;
        shift_s  = shift_r;
        parity_s = parity_r;
        cyc_s    = cyc_r;
        bit_s    = bit_r;
        done_s   = 1'b0;
        tx_s     = 1'b1;
        busy_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (start_s) begin
                    shift_s  = data_s;
                    parity_s = even_parity(data_s);
                    cyc_s    = {CW{1'b0}};
                    bit_s    = {BW{1'b0}};
                    state_s  = START;
                end else begin
                    state_s  = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    cyc_s   = {CW{1'b0}};
                    state_s = DATA;
                end else begin
                    cyc_s   = cyc_r + CW'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cyc_s   = {CW{1'b0}};
                    shift_s = {shift_r[WIDTH-2:0], 1'b0};
                    if (bit_r == BIT_LAST) begin
                        bit_s   = {BW{1'b0}};
                        state_s = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_s   = bit_r + BW'(1);
                    end
                end else begin
                    cyc_s   = cyc_r + CW'(1);
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    cyc_s   = {CW{1'b0}};
                    state_s = STOP;
                end else begin
                    cyc_s   = cyc_r + CW'(1);
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    cyc_s   = {CW{1'b0}};
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    cyc_s   = cyc_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cyc_s   = {CW{1'b0}};
                bit_s   = {BW{1'b0}};
            end
        endcase

        case (state_s)
            IDLE:    begin tx_s = 1'b1;               busy_s = 1'b0; end
            START:   begin tx_s = 1'b0;               busy_s = 1'b1; end
            DATA:    begin tx_s = shift_s[WIDTH-1];   busy_s = 1'b1; end
            PARITY:  begin tx_s = parity_s;           busy_s = 1'b1; end
            STOP:    begin tx_s = 1'b1;               busy_s = 1'b1; end
            default: begin tx_s = 1'b1;               busy_s = 1'b0; end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge input_clock1_clk_1 or negedge input_push_button2_rst_n_2) begin
        if (!input_push_button2_rst_n_2) begin
            state_r  <= IDLE;
            shift_r  <= {WIDTH{1'b0}};
            parity_r <= 1'b0;
            cyc_r    <= {CW{1'b0}};
            bit_r    <= {BW{1'b0}};
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            shift_r  <= shift_s;
            parity_r <= parity_s;
            cyc_r    <= cyc_s;
            bit_r    <= bit_s;
            tx_r     <= tx_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign bus.output_led1_tx_5   = tx_r;
    assign bus.output_led2_busy_6 = busy_r;
    assign bus.output_led3_done_7 = done_r;
endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Directed bench for serial_frame_transmitter: unit A (8 bits, 1 cycle/bit,
// no parity) and unit B (8 bits, 3 cycles/bit, even parity) share clock/reset.
module tb_serial_frame_transmitter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    serial_frame_transmitter_if #(.WIDTH(8)) bus_a ();
    serial_frame_transmitter_if #(.WIDTH(8)) bus_b ();

    serial_frame_transmitter #(.WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(0)) dut_a (
        .input_clock1_clk_1         (clk),
        .input_push_button2_rst_n_2 (rst_n),
        .bus                        (bus_a.slave)
    );

    serial_frame_transmitter #(.WIDTH(8), .BIT_CYCLES(3), .PARITY_EN(1)) dut_b (
        .input_clock1_clk_1         (clk),
        .input_push_button2_rst_n_2 (rst_n),
        .bus                        (bus_b.slave)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if observed differs from expected.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic tx_of(input int u);
        return (u == 0) ? bus_a.output_led1_tx_5 : bus_b.output_led1_tx_5;
    endfunction
    function automatic logic busy_of(input int u);
        return (u == 0) ? bus_a.output_led2_busy_6 : bus_b.output_led2_busy_6;
    endfunction
    function automatic logic done_of(input int u);
        return (u == 0) ? bus_a.output_led3_done_7 : bus_b.output_led3_done_7;
    endfunction

    // Expected tx for cycle j after the accepting edge (j=0 is the start bit).
    function automatic logic exp_bit(input int u, input logic [7:0] d, input logic par, input int j);
        int bc;
        int b;
        bc = (u == 0) ? 1 : 3;
        b  = j / bc;
        if (b == 0)                 return 1'b0;
        else if (b <= 8)            return d[8 - b];
        else if (u == 1 && b == 9)  return par;
        else                        return 1'b1;
    endfunction

    // Assert start with data on one unit, return just after the accepting edge.
    task automatic accept(input int u, input logic [7:0] d, input bit hold);
        @(negedge clk);
        if (u == 0) begin
            bus_a.input_push_button3_start_3 = 1'b1;
            bus_a.input_switch4_data_4       = d;
        end else begin
            bus_b.input_push_button3_start_3 = 1'b1;
            bus_b.input_switch4_data_4       = d;
        end
        @(negedge clk);
        if (!hold) begin
            if (u == 0) bus_a.input_push_button3_start_3 = 1'b0;
            else        bus_b.input_push_button3_start_3 = 1'b0;
        end
    endtask

    // Check a whole frame cycle by cycle starting just after edge k; ends just after k+F.
    // inject: 1 = pulse start with data 0 at k+4, 2 = switch data to 0xC3 mid-frame.
    task automatic check_frame(input int u, input logic [7:0] d, input logic par,
                               input int inject, output logic [9:0] seq);
        int f;
        f   = (u == 0) ? 10 : 33;
        seq = 10'd0;
        for (int j = 0; j < f; j++) begin
            check_val($sformatf("tx_u%0d_j%0d", u, j), {31'd0, tx_of(u)}, {31'd0, exp_bit(u, d, par, j)});
            check_val($sformatf("busy_u%0d_j%0d", u, j), {31'd0, busy_of(u)}, 32'd1);
            check_val($sformatf("done_u%0d_j%0d", u, j), {31'd0, done_of(u)}, 32'd0);
            if (u == 0) seq = {seq[8:0], tx_of(u)};
            if (inject == 1 && j == 3) begin
                bus_a.input_push_button3_start_3 = 1'b1;
                bus_a.input_switch4_data_4       = 8'h00;
            end
            if (inject == 1 && j == 4) bus_a.input_push_button3_start_3 = 1'b0;
            if (inject == 2 && j == 5) bus_a.input_switch4_data_4 = 8'hC3;
            @(negedge clk);
        end
        check_val($sformatf("end_done_u%0d", u), {31'd0, done_of(u)}, 32'd1);
        check_val($sformatf("end_busy_u%0d", u), {31'd0, busy_of(u)}, 32'd0);
        check_val($sformatf("end_tx_u%0d", u), {31'd0, tx_of(u)}, 32'd1);
    endtask

    // Directed test sequence.
    initial begin
        logic [9:0] seq;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus_a.input_push_button3_start_3 = 1'b1;
        bus_a.input_switch4_data_4       = 8'hFF;
        bus_b.input_push_button3_start_3 = 1'b1;
        bus_b.input_switch4_data_4       = 8'hFF;

        // Reset held with start=1, data=0xFF.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                check_val($sformatf("rst_tx_u%0d", u), {31'd0, tx_of(u)}, 32'd1);
                check_val($sformatf("rst_busy_u%0d", u), {31'd0, busy_of(u)}, 32'd0);
                check_val($sformatf("rst_done_u%0d", u), {31'd0, done_of(u)}, 32'd0);
            end
        end
        bus_a.input_push_button3_start_3 = 1'b0;
        bus_b.input_push_button3_start_3 = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("post_rst_busy_a", {31'd0, busy_of(0)}, 32'd0);
            check_val("post_rst_tx_a", {31'd0, tx_of(0)}, 32'd1);
            check_val("post_rst_busy_b", {31'd0, busy_of(1)}, 32'd0);
        end

        // Basic frame 0xA5, one cycle per bit.
        accept(0, 8'hA5, 1'b0);
        check_frame(0, 8'hA5, 1'b0, 0, seq);
        check_val("a5_seq", {22'd0, seq}, {22'd0, 10'b0101001011});
        @(negedge clk);
        check_val("a5_done_fall", {31'd0, done_of(0)}, 32'd0);

        // Parity and stretch on unit B.
        accept(1, 8'h07, 1'b0);
        check_frame(1, 8'h07, 1'b1, 0, seq);
        @(negedge clk);
        check_val("b07_done_fall", {31'd0, done_of(1)}, 32'd0);
        accept(1, 8'hA5, 1'b0);
        check_frame(1, 8'hA5, 1'b0, 0, seq);
        @(negedge clk);
        check_val("ba5_done_fall", {31'd0, done_of(1)}, 32'd0);

        // Start during a frame is ignored and not queued.
        accept(0, 8'hA5, 1'b0);
        check_frame(0, 8'hA5, 1'b0, 1, seq);
        check_val("ign_seq", {22'd0, seq}, {22'd0, 10'b0101001011});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("ign_no_second_busy", {31'd0, busy_of(0)}, 32'd0);
            check_val("ign_no_second_tx", {31'd0, tx_of(0)}, 32'd1);
        end

        // Back-to-back with start held high; data switched mid-frame.
        accept(0, 8'h3C, 1'b1);
        check_frame(0, 8'h3C, 1'b0, 2, seq);
        @(negedge clk);
        check_val("b2b_second_start_tx", {31'd0, tx_of(0)}, 32'd0);
        check_val("b2b_second_busy", {31'd0, busy_of(0)}, 32'd1);
        check_val("b2b_done_fall", {31'd0, done_of(0)}, 32'd0);
        bus_a.input_push_button3_start_3 = 1'b0;
        check_frame(0, 8'hC3, 1'b0, 0, seq);
        check_val("b2b_c3_seq", {22'd0, seq}, {22'd0, 10'b0110000111});
        @(negedge clk);

        // Abort mid-frame with an asynchronous reset pulse.
        accept(0, 8'h5A, 1'b0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        @(posedge clk);
        #2;
        check_val("abort_pre_busy", {31'd0, busy_of(0)}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("abort_tx", {31'd0, tx_of(0)}, 32'd1);
        check_val("abort_busy", {31'd0, busy_of(0)}, 32'd0);
        check_val("abort_done", {31'd0, done_of(0)}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("abort_no_done", {31'd0, done_of(0)}, 32'd0);
            check_val("abort_idle_busy", {31'd0, busy_of(0)}, 32'd0);
        end
        accept(0, 8'hA5, 1'b0);
        check_frame(0, 8'hA5, 1'b0, 0, seq);
        check_val("abort_next_seq", {22'd0, seq}, {22'd0, 10'b0101001011});
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
